// File: rtl/w_pkg.sv
// rtl/w_pkg.sv - shared FSM state encoding and delta saturation limits for w_update_ctrl.
package w_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_LOAD = 2'd2
  } w_state_t;

  // Wide enough to hold any sign-extended 2*IN_W product for IN_W up to 64.
  localparam int W_SAT_CALC_W = 256;

  function automatic logic signed [W_SAT_CALC_W-1:0] w_sat_max(input int w);
    return (W_SAT_CALC_W'(1) << (w - 1)) - W_SAT_CALC_W'(1);
  endfunction

  function automatic logic signed [W_SAT_CALC_W-1:0] w_sat_min(input int w);
    return -(W_SAT_CALC_W'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/w_delta_mac.sv
// rtl/w_delta_mac.sv - delta = (err * x) >>> MU_SHIFT, reduced to COEFF_W bits.
// W_UPD_SAT_EN selects saturation; otherwise the result wraps to its low COEFF_W bits.
module w_delta_mac
  import w_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int COEFF_W  = 32,
  parameter int MU_SHIFT = 40
) (
  input  logic [IN_W-1:0]    i_err,
  input  logic [IN_W-1:0]    i_x,
  output logic [COEFF_W-1:0] o_delta
);

  localparam int P_W = 2 * IN_W;

  logic signed [P_W-1:0]          w_err_ext;
  logic signed [P_W-1:0]          w_x_ext;
  logic signed [P_W-1:0]          w_prod;
  logic signed [P_W-1:0]          w_shift;
  logic signed [W_SAT_CALC_W-1:0] w_ext;

  assign w_err_ext = {{IN_W{i_err[IN_W-1]}}, i_err};
  assign w_x_ext   = {{IN_W{i_x[IN_W-1]}}, i_x};
  assign w_prod    = w_err_ext * w_x_ext;
  assign w_shift   = w_prod >>> MU_SHIFT;
  assign w_ext     = {{(W_SAT_CALC_W-P_W){w_shift[P_W-1]}}, w_shift};

`ifdef W_UPD_SAT_EN
  localparam logic signed [W_SAT_CALC_W-1:0] L_MAX = w_sat_max(COEFF_W);
  localparam logic signed [W_SAT_CALC_W-1:0] L_MIN = w_sat_min(COEFF_W);

  always_comb begin
    o_delta = w_ext[COEFF_W-1:0];
    if (w_ext > L_MAX) begin
      o_delta = L_MAX[COEFF_W-1:0];
    end else if (w_ext < L_MIN) begin
      o_delta = L_MIN[COEFF_W-1:0];
    end
  end
`else
  logic w_unused_bits;

  assign o_delta       = w_ext[COEFF_W-1:0];
  assign w_unused_bits = ^w_ext;
`endif

endmodule

// File: rtl/w_update_ctrl.sv
// rtl/w_update_ctrl.sv - LMS-style weight delta sequencer: snapshot history, one delta per cycle, single load strobe.
// Delta reduction mode follows macro W_UPD_SAT_EN (saturate) or its absence (wrap).
module w_update_ctrl
  import w_pkg::*;
#(
  parameter int N        = 32,
  parameter int IN_W     = 32,
  parameter int COEFF_W  = 32,
  parameter int MU_SHIFT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 x_valid,
  input  logic [IN_W-1:0]      x_in,
  input  logic                 err_valid,
  input  logic [IN_W-1:0]      err_in,
  input  logic                 update_en,
  input  logic                 abort,
  output logic [N*COEFF_W-1:0] weight_in,
  output logic                 weight_load_en,
  output logic                 busy,
  output logic                 drop
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  w_state_t                    r_state;
  w_state_t                    w_next;
  logic [N-1:0][IN_W-1:0]      r_xh;
  logic [N-1:0][IN_W-1:0]      r_xs;
  logic [N-1:0][COEFF_W-1:0]   r_weight;
  logic [IN_W-1:0]             r_err;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_drop;
  logic                        w_accept;
  logic [IN_W-1:0]             w_xsel;
  logic [COEFF_W-1:0]          w_delta;

  // Abort in IDLE does not cancel anything but still refuses a coincident error sample.
  assign w_accept  = (r_state == ST_IDLE) && err_valid && update_en && !abort;
  assign w_xsel    = r_xs[r_idx];
  assign weight_in = r_weight;
  assign drop      = r_drop;

  w_delta_mac #(
    .IN_W     (IN_W),
    .COEFF_W  (COEFF_W),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .i_err   (r_err),
    .i_x     (w_xsel),
    .o_delta (w_delta)
  );

  always_comb begin
    w_next         = r_state;
    weight_load_en = 1'b0;
    busy           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (r_idx == IDX_W'(N - 1)) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy           = 1'b1;
        weight_load_en = !abort;
        w_next         = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_xh     <= '0;
      r_xs     <= '0;
      r_weight <= '0;
      r_err    <= '0;
      r_idx    <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= err_valid && !w_accept;
      if (x_valid) begin
        r_xh[0] <= x_in;
        for (int i = 1; i < N; i++) begin
          r_xh[i] <= r_xh[i-1];
        end
      end
      if (w_accept) begin
        r_err <= err_in;
        r_xs  <= r_xh;
        r_idx <= '0;
      end
      // The in-flight update reads only r_xs, so live history may keep shifting.
      if ((r_state == ST_CALC) && !abort) begin
        r_weight[r_idx] <= w_delta;
        r_idx           <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_w_update_ctrl.sv
// tb/tb_w_update_ctrl.sv - randomized self-checking bench for w_update_ctrl against a queue-level reference model.
module tb_w_update_ctrl;

  localparam int N       = 4;
  localparam int IN_W    = 8;
  localparam int COEFF_W = 8;
  localparam int MU      = 0;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 x_valid;
  logic [IN_W-1:0]      x_in;
  logic                 err_valid;
  logic [IN_W-1:0]      err_in;
  logic                 update_en;
  logic                 abort;
  logic [N*COEFF_W-1:0] weight_in;
  logic                 weight_load_en;
  logic                 busy;
  logic                 drop;

  int vectors    = 0;
  int miscompares = 0;
  int hist[N];
  int snap[N];
  int cur_err;
  int load_cnt;
  int drop_cnt;

  w_update_ctrl #(
    .N        (N),
    .IN_W     (IN_W),
    .COEFF_W  (COEFF_W),
    .MU_SHIFT (MU)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .x_valid        (x_valid),
    .x_in           (x_in),
    .err_valid      (err_valid),
    .err_in         (err_in),
    .update_en      (update_en),
    .abort          (abort),
    .weight_in      (weight_in),
    .weight_load_en (weight_load_en),
    .busy           (busy),
    .drop           (drop)
  );

  always #5 clock = ~clock;

  function automatic int model_delta(int e, int x);
    longint p;
    p = longint'(e) * longint'(x);
    p = p >>> MU;
`ifdef W_UPD_SAT_EN
    if (p > 127) return 127;
    if (p < -128) return -128;
    return int'(p);
`else
    p = ((p % 256) + 256) % 256;
    if (p >= 128) p = p - 256;
    return int'(p);
`endif
  endfunction

  function automatic logic [N*COEFF_W-1:0] pack_exp(int e, int xs[N]);
    logic [N*COEFF_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*COEFF_W +: COEFF_W] = 8'(model_delta(e, xs[i]));
    return v;
  endfunction

  task automatic tick();
    if (x_valid && !reset) begin
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'($signed(x_in));
    end
    @(posedge clock);
    #1;
    if (weight_load_en) load_cnt++;
    if (drop) drop_cnt++;
  endtask

  task automatic push_x(int v);
    x_valid = 1'b1;
    x_in    = 8'(v);
    tick();
    x_valid = 1'b0;
  endtask

  task automatic accept(int e);
    err_valid = 1'b1;
    err_in    = 8'(e);
    update_en = 1'b1;
    cur_err   = int'($signed(err_in));
    for (int i = 0; i < N; i++) snap[i] = hist[i];
    tick();
    err_valid = 1'b0;
  endtask

  task automatic wait_load(input bit live_x, output int edges);
    int start;
    start = load_cnt;
    edges = 0;
    while (load_cnt == start && edges < 20) begin
      if (live_x) begin
        x_valid = 1'b1;
        x_in    = 8'($urandom_range(0, 255));
      end
      tick();
      edges++;
    end
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; x_valid = 0; x_in = 0; err_valid = 0; err_in = 0; update_en = 1; abort = 0;
    for (int i = 0; i < N; i++) hist[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (weight_load_en !== 1'b0) begin miscompares++; $display("FAIL reset_load got %b want 0", weight_load_en); end
    vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop got %b want 0", drop); end
    vectors++; if (weight_in !== '0) begin miscompares++; $display("FAIL reset_weight got %h want 0", weight_in); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int edges;
    push_x(4); push_x(3); push_x(2); push_x(1);
    load_cnt = 0;
    accept(2);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_load(1'b0, edges);
    vectors++; if (edges != N) begin miscompares++; $display("FAIL basic_latency got %0d edges want %0d", edges, N); end
    vectors++; if (weight_in !== 32'h0806_0402) begin miscompares++; $display("FAIL basic_weight got %h want 08060402", weight_in); end
    repeat (3) tick();
    vectors++; if (load_cnt != 1) begin miscompares++; $display("FAIL basic_load_count got %0d want 1", load_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle got %b want 0", busy); end
  endtask

  task automatic test_drop();
    int edges;
    logic [N*COEFF_W-1:0] exp_w;
    for (int i = 0; i < N; i++) push_x($urandom_range(0, 255));
    load_cnt = 0; drop_cnt = 0;
    accept(3);
    exp_w = pack_exp(cur_err, snap);
    tick();
    err_valid = 1'b1; err_in = 8'd55;
    tick();
    err_valid = 1'b0;
    wait_load(1'b0, edges);
    repeat (3) tick();
    vectors++; if (drop_cnt != 1) begin miscompares++; $display("FAIL busy_drop got %0d want 1", drop_cnt); end
    vectors++; if (load_cnt != 1) begin miscompares++; $display("FAIL busy_drop_loads got %0d want 1", load_cnt); end
    vectors++; if (weight_in !== exp_w) begin miscompares++; $display("FAIL busy_drop_weight got %h want %h", weight_in, exp_w); end
    update_en = 1'b0; err_valid = 1'b1;
    tick();
    err_valid = 1'b0; update_en = 1'b1;
    tick();
    vectors++; if (drop_cnt != 2 || busy !== 1'b0) begin miscompares++; $display("FAIL gated_drop got drops=%0d busy=%b want 2,0", drop_cnt, busy); end
    abort = 1'b1; err_valid = 1'b1;
    tick();
    abort = 1'b0; err_valid = 1'b0;
    tick();
    vectors++; if (drop_cnt != 3 || busy !== 1'b0 || load_cnt != 1) begin miscompares++; $display("FAIL idle_abort got drops=%0d busy=%b loads=%0d want 3,0,1", drop_cnt, busy, load_cnt); end
  endtask

  task automatic test_abort();
    int edges;
    logic [N*COEFF_W-1:0] exp_w;
    for (int i = 0; i < N; i++) push_x($urandom_range(0, 255));
    load_cnt = 0;
    accept($urandom_range(0, 255));
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (6) tick();
    vectors++; if (load_cnt != 0) begin miscompares++; $display("FAIL abort_no_load got %0d want 0", load_cnt); end
    push_x($urandom_range(0, 255));
    accept($urandom_range(0, 255));
    exp_w = pack_exp(cur_err, snap);
    wait_load(1'b0, edges);
    vectors++; if (edges != N) begin miscompares++; $display("FAIL abort_resume_latency got %0d want %0d", edges, N); end
    vectors++; if (weight_in !== exp_w) begin miscompares++; $display("FAIL abort_resume_weight got %h want %h", weight_in, exp_w); end
    tick();
    vectors++; if (load_cnt != 1) begin miscompares++; $display("FAIL abort_resume_loads got %0d want 1", load_cnt); end
  endtask

  task automatic test_sat();
    int edges;
    logic [COEFF_W-1:0] slot_exp;
`ifdef W_UPD_SAT_EN
    slot_exp = 8'd127;
`else
    slot_exp = 8'd16;
`endif
    for (int i = 0; i < N; i++) push_x(100);
    accept(100);
    wait_load(1'b0, edges);
    vectors++; if (weight_in[COEFF_W-1:0] !== slot_exp) begin miscompares++; $display("FAIL sat_slot0 got %0d want %0d", weight_in[COEFF_W-1:0], slot_exp); end
    vectors++; if (weight_in !== {N{slot_exp}}) begin miscompares++; $display("FAIL sat_all got %h want %h", weight_in, {N{slot_exp}}); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) push_x($urandom_range(1, 255));
    load_cnt = 0; drop_cnt = 0;
    accept($urandom_range(1, 127));
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || weight_load_en !== 1'b0 || drop !== 1'b0) begin miscompares++; $display("FAIL midreset_outs got busy=%b load=%b drop=%b want 0,0,0", busy, weight_load_en, drop); end
    vectors++; if (weight_in !== '0) begin miscompares++; $display("FAIL midreset_weight got %h want 0", weight_in); end
    for (int i = 0; i < N; i++) hist[i] = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) tick();
    vectors++; if (load_cnt != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_after got loads=%0d busy=%b want 0,0", load_cnt, busy); end
  endtask

  task automatic test_snapshot_random();
    int edges;
    logic [N*COEFF_W-1:0] exp_w;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < N; i++) push_x($urandom_range(0, 255));
      x_valid = 1'b1;
      x_in    = 8'($urandom_range(0, 255));
      accept($urandom_range(0, 255));
      exp_w = pack_exp(cur_err, snap);
      wait_load(1'b1, edges);
      vectors++; if (edges != N) begin miscompares++; $display("FAIL snap_latency it=%0d got %0d want %0d", it, edges, N); end
      vectors++; if (weight_in !== exp_w) begin miscompares++; $display("FAIL snap_weight it=%0d got %h want %h", it, weight_in, exp_w); end
      tick();
    end
  endtask

  initial begin
    load_cnt = 0; drop_cnt = 0; cur_err = 0;
    test_reset();
    test_basic();
    test_drop();
    test_abort();
    test_sat();
    test_reset_mid();
    test_snapshot_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
